// File: rtl/obstacle_pkg.sv
`default_nettype none
// ============================================================
// obstacle_pkg : shared obstacle geometry, widths and game state
// Rev 1.0
// ============================================================
package obstacle_pkg;

  localparam int NUM_OBS     = 10;
  localparam int X_W         = 10;
  localparam int Y_W         = 9;
  localparam int SCREEN_W    = 640;
  localparam int UPPER_BOUND = 20;
  localparam int LOWER_BOUND = 460;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_e;

  // Obstacle heights step from 80 to 200 pixels in 40-pixel increments.
  function automatic logic [Y_W-1:0] obs_height(input logic [1:0] sel);
    return Y_W'(80) + Y_W'(40) * Y_W'(sel);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================
// lfsr16 : free-running 16-bit Fibonacci LFSR (taps 16,14,13,11)
// Rev 1.0
// ============================================================
module lfsr16
  import obstacle_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] rnd
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Right-shifting form: feedback enters at bit 15.
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rnd = lfsr_q[2:0];

endmodule
`default_nettype wire

// File: rtl/obstacle_scheduler.sv
`default_nettype none
// ============================================================
// obstacle_scheduler : spawns, scrolls and retires obstacle slots
// Rev 1.0
// ============================================================
module obstacle_scheduler #(
  parameter int NUM_OBS   = obstacle_pkg::NUM_OBS,
  parameter int SPAWN_GAP = 60,
  parameter int SPEED     = 4,
  parameter int OBS_W     = 40
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [1:0]                                gamemode,
  input  logic                                      frame_tick,
  output logic [NUM_OBS-1:0][obstacle_pkg::X_W-1:0] obstacle_x_game_left,
  output logic [NUM_OBS-1:0][obstacle_pkg::X_W-1:0] obstacle_x_game_right,
  output logic [NUM_OBS-1:0][obstacle_pkg::Y_W-1:0] obstacle_y_game_up,
  output logic [NUM_OBS-1:0][obstacle_pkg::Y_W-1:0] obstacle_y_game_down,
  output logic [NUM_OBS-1:0]                        obs_active,
  output logic [15:0]                               obs_passed
);
  import obstacle_pkg::*;

  localparam int                CNT_W    = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam int                RET_W    = $clog2(NUM_OBS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SPAWN_GAP - 1);
  localparam logic [X_W-1:0]    SPEED_X  = X_W'(SPEED);
  localparam logic [X_W-1:0]    SPAWN_L  = X_W'(SCREEN_W);
  localparam logic [X_W-1:0]    SPAWN_R  = X_W'(SCREEN_W + OBS_W);
  localparam logic [Y_W-1:0]    TOP_Y    = Y_W'(UPPER_BOUND + 1);
  localparam logic [Y_W-1:0]    BOT_Y    = Y_W'(LOWER_BOUND);

  state_e                      state_q, state_d;
  logic [NUM_OBS-1:0][X_W-1:0] left_q, left_d, right_q, right_d;
  logic [NUM_OBS-1:0][Y_W-1:0] up_q, up_d, down_q, down_d;
  logic [NUM_OBS-1:0]          active_q, active_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [15:0]                 passed_q, passed_d;

  logic [2:0]       rnd;
  logic [Y_W-1:0]   height;
  logic [RET_W-1:0] retired;
  logic [16:0]      passed_sum;
  logic             clear_all;
  logic             run_tick;
  logic             spawn_done;

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .rnd (rnd)
  );

  always_comb begin
    state_d    = state_e'(gamemode);
    left_d     = left_q;
    right_d    = right_q;
    up_d       = up_q;
    down_d     = down_q;
    active_d   = active_q;
    cnt_d      = cnt_q;
    passed_d   = passed_q;
    retired    = '0;
    passed_sum = '0;
    spawn_done = 1'b0;
    height     = obs_height(rnd[1:0]);

    // A fresh game (or going back to the title) wipes everything and swallows any tick.
    clear_all = (state_d == ST_IDLE) ||
                ((state_d == ST_RUN) && ((state_q == ST_IDLE) || (state_q == ST_OVER)));
    run_tick  = (state_d == ST_RUN) && frame_tick && !clear_all;

    if (clear_all) begin
      left_d   = '0;
      right_d  = '0;
      up_d     = '0;
      down_d   = '0;
      active_d = '0;
      cnt_d    = '0;
      passed_d = '0;
    end else if (run_tick) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        if (active_q[i]) begin
          if (right_q[i] > SPEED_X) begin
            left_d[i]  = (left_q[i] > SPEED_X) ? (left_q[i] - SPEED_X) : '0;
            right_d[i] = right_q[i] - SPEED_X;
          end else begin
            active_d[i] = 1'b0;
            left_d[i]   = '0;
            right_d[i]  = '0;
            up_d[i]     = '0;
            down_d[i]   = '0;
            retired     = retired + RET_W'(1);
          end
        end
      end
      passed_sum = {1'b0, passed_q} + 17'(retired);
      passed_d   = passed_sum[16] ? 16'hFFFF : passed_sum[15:0];

      // Eligibility uses the pre-tick mask so a slot retired this tick stays empty.
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
          if (!spawn_done && !active_q[i]) begin
            spawn_done  = 1'b1;
            active_d[i] = 1'b1;
            left_d[i]   = SPAWN_L;
            right_d[i]  = SPAWN_R;
            if (rnd[2]) begin
              down_d[i] = BOT_Y;
              up_d[i]   = BOT_Y - height;
            end else begin
              up_d[i]   = TOP_Y;
              down_d[i] = TOP_Y + height;
            end
          end
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      left_q   <= '0;
      right_q  <= '0;
      up_q     <= '0;
      down_q   <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      passed_q <= '0;
    end else begin
      state_q  <= state_d;
      left_q   <= left_d;
      right_q  <= right_d;
      up_q     <= up_d;
      down_q   <= down_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      passed_q <= passed_d;
    end
  end

  assign obstacle_x_game_left  = left_q;
  assign obstacle_x_game_right = right_q;
  assign obstacle_y_game_up    = up_q;
  assign obstacle_y_game_down  = down_q;
  assign obs_active            = active_q;
  assign obs_passed            = passed_q;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_scheduler.sv
`default_nettype none
// ============================================================
// tb_obstacle_scheduler : directed bench with a behavioural model
// Rev 1.0
// ============================================================
module tb_obstacle_scheduler;

  localparam int N     = 10;
  localparam int SPD   = 4;
  localparam int OW    = 40;
  localparam int GAP_A = 60;
  localparam int GAP_B = 1;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [1:0] gm_a = 2'b00;
  logic [1:0] gm_b = 2'b00;
  logic       ft_a = 1'b0;
  logic       ft_b = 1'b0;

  logic [N-1:0][9:0] a_xl, a_xr, b_xl, b_xr;
  logic [N-1:0][8:0] a_yu, a_yd, b_yu, b_yd;
  logic [N-1:0]      a_act, b_act;
  logic [15:0]       a_pass, b_pass;

  always #5 clk = ~clk;

  obstacle_scheduler #(.NUM_OBS(N), .SPAWN_GAP(GAP_A), .SPEED(SPD), .OBS_W(OW)) dut_a (
    .clk(clk), .rst(rst), .gamemode(gm_a), .frame_tick(ft_a),
    .obstacle_x_game_left(a_xl), .obstacle_x_game_right(a_xr),
    .obstacle_y_game_up(a_yu), .obstacle_y_game_down(a_yd),
    .obs_active(a_act), .obs_passed(a_pass)
  );

  obstacle_scheduler #(.NUM_OBS(N), .SPAWN_GAP(GAP_B), .SPEED(SPD), .OBS_W(OW)) dut_b (
    .clk(clk), .rst(rst), .gamemode(gm_b), .frame_tick(ft_b),
    .obstacle_x_game_left(b_xl), .obstacle_x_game_right(b_xr),
    .obstacle_y_game_up(b_yu), .obstacle_y_game_down(b_yd),
    .obs_active(b_act), .obs_passed(b_pass)
  );

  // ---------------- behavioural model ----------------
  int m_l [2][N];
  int m_r [2][N];
  int m_u [2][N];
  int m_d [2][N];
  bit m_act [2][N];
  int m_ticks [2];
  int m_pass [2];
  int m_mode [2];
  int m_lfsr = 'hACE1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic m_clear(input int k);
    for (int i = 0; i < N; i++) begin
      m_act[k][i] = 1'b0;
      m_l[k][i] = 0; m_r[k][i] = 0; m_u[k][i] = 0; m_d[k][i] = 0;
    end
    m_ticks[k] = 0;
    m_pass[k]  = 0;
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_clear(k);
      m_mode[k] = 0;
    end
    m_lfsr = 'hACE1;
  endtask

  task automatic m_step(input int k, input int mode, input bit tick, input int gap);
    bit pre [N];
    bit placed;
    int h;
    placed = 1'b0;
    if (mode == 0 || (mode == 1 && (m_mode[k] == 0 || m_mode[k] == 3))) begin
      m_clear(k);
    end else if (mode == 1 && tick) begin
      for (int i = 0; i < N; i++) pre[i] = m_act[k][i];
      for (int i = 0; i < N; i++) begin
        if (pre[i]) begin
          if (m_r[k][i] > SPD) begin
            m_r[k][i] = m_r[k][i] - SPD;
            m_l[k][i] = (m_l[k][i] - SPD < 0) ? 0 : m_l[k][i] - SPD;
          end else begin
            m_act[k][i] = 1'b0;
            m_l[k][i] = 0; m_r[k][i] = 0; m_u[k][i] = 0; m_d[k][i] = 0;
            if (m_pass[k] < 65535) m_pass[k] = m_pass[k] + 1;
          end
        end
      end
      // Every gap-th run tick is a spawn attempt.
      m_ticks[k] = (m_ticks[k] + 1) % gap;
      if (m_ticks[k] == 0) begin
        for (int i = 0; i < N; i++) begin
          if (!placed && !pre[i]) begin
            placed = 1'b1;
            h = 80 + 40 * (m_lfsr % 4);
            m_act[k][i] = 1'b1;
            m_l[k][i] = 640;
            m_r[k][i] = 640 + OW;
            if (((m_lfsr >> 2) & 1) == 1) begin
              m_d[k][i] = 460; m_u[k][i] = 460 - h;
            end else begin
              m_u[k][i] = 21; m_d[k][i] = 21 + h;
            end
          end
        end
      end
    end
    m_mode[k] = mode;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_reset();
      end else begin
        m_step(0, int'(gm_a), ft_a, GAP_A);
        m_step(1, int'(gm_b), ft_b, GAP_B);
        m_lfsr = (m_lfsr >> 1) |
                 ((((m_lfsr) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int idx, input longint act, input longint exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s[%0d] @%0t: got 0x%0h expected 0x%0h", name, idx, $time, act, exp);
    end
  endtask

  function automatic longint pack_slot(input bit a, input int l, input int r, input int u, input int d);
    return {25'd0, a, 10'(l), 10'(r), 9'(u), 9'(d)};
  endfunction

  function automatic bit shape_ok(input int u, input int d);
    int h;
    h = d - u;
    return (h == 80 || h == 120 || h == 160 || h == 200) && (u == 21 || d == 460);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int i = 0; i < N; i++) begin
          check("slot_a", i,
                pack_slot(a_act[i], int'(a_xl[i]), int'(a_xr[i]), int'(a_yu[i]), int'(a_yd[i])),
                pack_slot(m_act[0][i], m_l[0][i], m_r[0][i], m_u[0][i], m_d[0][i]));
          check("slot_b", i,
                pack_slot(b_act[i], int'(b_xl[i]), int'(b_xr[i]), int'(b_yu[i]), int'(b_yd[i])),
                pack_slot(m_act[1][i], m_l[1][i], m_r[1][i], m_u[1][i], m_d[1][i]));
        end
        check("passed_a", 0, longint'(a_pass), longint'(m_pass[0]));
        check("passed_b", 0, longint'(b_pass), longint'(m_pass[1]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_a(input int n);
    repeat (n) begin
      @(negedge clk); ft_a = 1'b1;
      @(negedge clk); ft_a = 1'b0;
    end
  endtask

  task automatic pulse_b(input int n);
    repeat (n) begin
      @(negedge clk); ft_b = 1'b1;
      @(negedge clk); ft_b = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    check("rst_act_a", 0, longint'(a_act), 64'd0);
    check("rst_pass_a", 0, longint'(a_pass), 64'd0);
    check("rst_xl_a", 0, longint'(a_xl[0]), 64'd0);
    check("rst_yd_b", 3, longint'(b_yd[3]), 64'd0);

    // First spawn lands on the 60th run tick.
    @(negedge clk); gm_a = 2'b01;
    @(negedge clk);
    pulse_a(59);
    check("pre_spawn_act", 0, longint'(a_act), 64'd0);
    pulse_a(1);
    check("spawn_act", 0, longint'(a_act), 64'h001);
    check("spawn_left", 0, longint'(a_xl[0]), 64'd640);
    check("spawn_right", 0, longint'(a_xr[0]), 64'd680);
    check("spawn_y_shape", 0, longint'(shape_ok(int'(a_yu[0]), int'(a_yd[0]))), 64'd1);
    pulse_a(1);
    check("scroll_left", 0, longint'(a_xl[0]), 64'd636);
    check("scroll_right", 0, longint'(a_xr[0]), 64'd676);

    // Slot 0 reaches right==4 after 169 scrolls and retires on the 170th.
    pulse_a(168);
    check("edge_right", 0, longint'(a_xr[0]), 64'd4);
    check("edge_act", 0, longint'(a_act), 64'h007);
    pulse_a(1);
    check("retire_act", 0, longint'(a_act), 64'h006);
    check("retire_pass", 0, longint'(a_pass), 64'd1);
    check("slot1_left", 1, longint'(a_xl[1]), 64'd200);
    check("slot2_left", 2, longint'(a_xl[2]), 64'd440);

    // Pause freezes, resume with a coincident tick scrolls immediately.
    @(negedge clk); gm_a = 2'b10;
    pulse_a(5);
    check("pause_left", 1, longint'(a_xl[1]), 64'd200);
    check("pause_right", 1, longint'(a_xr[1]), 64'd240);
    @(negedge clk); gm_a = 2'b01; ft_a = 1'b1;
    @(negedge clk); ft_a = 1'b0;
    check("resume_left", 1, longint'(a_xl[1]), 64'd196);
    check("resume_right", 1, longint'(a_xr[1]), 64'd236);

    // Game over holds; restarting with a coincident tick clears and drops it.
    @(negedge clk); gm_a = 2'b11;
    pulse_a(3);
    check("over_left", 1, longint'(a_xl[1]), 64'd196);
    check("over_pass", 0, longint'(a_pass), 64'd1);
    @(negedge clk); gm_a = 2'b01; ft_a = 1'b1;
    @(negedge clk); ft_a = 1'b0;
    check("restart_act", 0, longint'(a_act), 64'd0);
    check("restart_pass", 0, longint'(a_pass), 64'd0);
    check("restart_left", 1, longint'(a_xl[1]), 64'd0);
    pulse_a(59);
    check("restart_nospawn", 0, longint'(a_act), 64'd0);
    pulse_a(1);
    check("restart_spawn", 0, longint'(a_act), 64'h001);
    @(negedge clk); gm_a = 2'b00;
    @(negedge clk);
    check("idle_act", 0, longint'(a_act), 64'd0);
    check("idle_left", 0, longint'(a_xl[0]), 64'd0);
    check("idle_up", 0, longint'(a_yu[0]), 64'd0);

    // Spawn every tick: ten fill the slots, the eleventh is dropped.
    @(negedge clk); gm_b = 2'b01;
    @(negedge clk);
    pulse_b(10);
    check("full_act", 0, longint'(b_act), 64'h3FF);
    check("full_left0", 0, longint'(b_xl[0]), 64'd604);
    check("full_left9", 9, longint'(b_xl[9]), 64'd640);
    pulse_b(1);
    check("drop_act", 0, longint'(b_act), 64'h3FF);
    check("drop_left9", 9, longint'(b_xl[9]), 64'd636);
    check("drop_left0", 0, longint'(b_xl[0]), 64'd600);

    // Asynchronous reset between edges takes effect without a clock.
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_act", 0, longint'(b_act), 64'd0);
    check("async_left", 0, longint'(b_xl[0]), 64'd0);
    check("async_down", 5, longint'(b_yd[5]), 64'd0);
    @(negedge clk); rst = 1'b0;
    pulse_b(15);
    check("post_rst_act", 0, longint'(b_act), 64'h3FF);
    check("post_rst_left0", 0, longint'(b_xl[0]), 64'd584);

    @(negedge clk); gm_b = 2'b00;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
